tdm_demux_1_4: RTL and testbench

Receive-side counterpart of the 4:1 selector. A transmitter scans a 4:1 selector with a rotating 2-bit select and places four channels A, B, C, D on one time-division-multiplexed wire with a frame marker on channel A's slot. This block locks to that marker, de-interleaves the serial slots into a shadow buffer and updates four registered channel outputs atomically once per complete frame. It reports lock status and framing errors.

---
 rtl/tdm_demux_1_4.sv | 134 +++++++++++++
 tb/tb_tdm_demux_1_4.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1_4.sv
// Receive side of a 4-slot TDM link: locks to the slot-0 marker, de-interleaves
// slots into a shadow buffer and updates the four channel outputs once per frame.
module tdm_demux_1_4 #(
   parameter int unsigned W = 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [W-1:0] IN,
   input  logic         EN,
   input  logic         SYNC,
   output logic [W-1:0] A,
   output logic [W-1:0] B,
   output logic [W-1:0] C,
   output logic [W-1:0] D,
   output logic [1:0]   SEL,
   output logic         VALID,
   output logic         LOCK,
   output logic         ERR
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     sel_q, sel_d;
   logic [W-1:0]   sh0_q, sh0_d;
   logic [W-1:0]   sh1_q, sh1_d;
   logic [W-1:0]   sh2_q, sh2_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   c_q, c_d;
   logic [W-1:0]   d_q, d_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= UNLOCKED;
         sel_q   <= '0;
         sh0_q   <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      sh0_d   = sh0_q;
      sh1_d   = sh1_q;
      sh2_d   = sh2_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      if (EN) begin
         unique case (state_q)
            UNLOCKED: begin
               if (SYNC) begin
                  sh0_d   = IN;
                  sel_d   = 2'd1;
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (SYNC) begin
                  // A marker anywhere but slot 0 abandons the partial frame and restarts it.
                  err_d = (sel_q != 2'd0);
                  sh0_d = IN;
                  sel_d = 2'd1;
               end else begin
                  unique case (sel_q)
                     2'd0: begin
                        err_d   = 1'b1;
                        state_d = UNLOCKED;
                     end
                     2'd1: begin
                        sh1_d = IN;
                        sel_d = 2'd2;
                     end
                     2'd2: begin
                        sh2_d = IN;
                        sel_d = 2'd3;
                     end
                     2'd3: begin
                        a_d     = sh0_q;
                        b_d     = sh1_q;
                        c_d     = sh2_q;
                        d_d     = IN;
                        valid_d = 1'b1;
                        sel_d   = 2'd0;
                     end
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign A     = a_q;
   assign B     = b_q;
   assign C     = c_q;
   assign D     = d_q;
   assign SEL   = sel_q;
   assign VALID = valid_q;
   assign LOCK  = (state_q == LOCKED);
   assign ERR   = err_q;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed bench for tdm_demux_1_4 at W=8 with hand-computed expectations.
module tb_tdm_demux_1_4;

   localparam int unsigned W = 8;

   logic         CLK;
   logic         RST;
   logic [W-1:0] IN;
   logic         EN;
   logic         SYNC;
   logic [W-1:0] A, B, C, D;
   logic [1:0]   SEL;
   logic         VALID, LOCK, ERR;

   int unsigned  n_checks;
   int unsigned  n_fail;
   int unsigned  n_valid;
   int unsigned  n_err;

   tdm_demux_1_4 #(.W(W)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .IN    (IN),
      .EN    (EN),
      .SYNC  (SYNC),
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D),
      .SEL   (SEL),
      .VALID (VALID),
      .LOCK  (LOCK),
      .ERR   (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic en, input logic sync, input logic [W-1:0] data);
      @(negedge CLK);
      EN   = en;
      SYNC = sync;
      IN   = data;
      @(posedge CLK);
      #1;
      if (VALID) n_valid++;
      if (ERR)   n_err++;
      check("valid_err_excl", {31'd0, VALID & ERR}, 32'd0);
   endtask

   task automatic check_out(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                            input logic [W-1:0] ec, input logic [W-1:0] ed);
      check({tag, "_A"}, {24'd0, A}, {24'd0, ea});
      check({tag, "_B"}, {24'd0, B}, {24'd0, eb});
      check({tag, "_C"}, {24'd0, C}, {24'd0, ec});
      check({tag, "_D"}, {24'd0, D}, {24'd0, ed});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_valid  = 0;
      n_err    = 0;
      RST  = 1'b1;
      EN   = 1'b0;
      SYNC = 1'b0;
      IN   = '0;
      #1;
      check_out("rst0", 8'h00, 8'h00, 8'h00, 8'h00);
      check("rst0_SEL",   {30'd0, SEL}, 32'd0);
      check("rst0_LOCK",  {31'd0, LOCK}, 32'd0);
      check("rst0_VALID", {31'd0, VALID}, 32'd0);
      check("rst0_ERR",   {31'd0, ERR}, 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;

      // Pre-lock garbage: discarded silently.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 8'hE0 + 8'(i));
         check("garbage_LOCK", {31'd0, LOCK}, 32'd0);
         check("garbage_ERR",  {31'd0, ERR}, 32'd0);
         check("garbage_SEL",  {30'd0, SEL}, 32'd0);
      end
      check_out("garbage", 8'h00, 8'h00, 8'h00, 8'h00);

      // Normal frame.
      n_valid = 0;
      step(1'b1, 1'b1, 8'h11);
      check("f1_LOCK", {31'd0, LOCK}, 32'd1);
      check("f1_SEL1", {30'd0, SEL}, 32'd1);
      step(1'b1, 1'b0, 8'h22);
      check("f1_SEL2", {30'd0, SEL}, 32'd2);
      step(1'b1, 1'b0, 8'h33);
      check("f1_SEL3", {30'd0, SEL}, 32'd3);
      check("f1_VALID_early", {31'd0, VALID}, 32'd0);
      check_out("f1_hold", 8'h00, 8'h00, 8'h00, 8'h00);
      step(1'b1, 1'b0, 8'h44);
      check_out("f1", 8'h11, 8'h22, 8'h33, 8'h44);
      check("f1_VALID", {31'd0, VALID}, 32'd1);
      check("f1_LOCK_end", {31'd0, LOCK}, 32'd1);
      check("f1_SEL0", {30'd0, SEL}, 32'd0);
      step(1'b0, 1'b0, 8'h00);
      check("f1_VALID_pulse", {31'd0, VALID}, 32'd0);

      // Second frame, back to back, updates atomically.
      step(1'b1, 1'b1, 8'hA0);
      step(1'b1, 1'b0, 8'hA1);
      step(1'b1, 1'b0, 8'hA2);
      check_out("f2_hold", 8'h11, 8'h22, 8'h33, 8'h44);
      step(1'b1, 1'b0, 8'hA3);
      check_out("f2", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
      check("f2_VALID", {31'd0, VALID}, 32'd1);
      check("f12_valid_count", n_valid, 32'd2);

      // Gapped frame: SEL holds across idle slots.
      n_valid = 0;
      step(1'b1, 1'b1, 8'h11);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'hFF);
         check("gap_SEL1", {30'd0, SEL}, 32'd1);
      end
      step(1'b1, 1'b0, 8'h22);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 8'hFF);
         check("gap_SEL2", {30'd0, SEL}, 32'd2);
      end
      step(1'b1, 1'b0, 8'h33);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 8'hFF);
         check("gap_SEL3", {30'd0, SEL}, 32'd3);
      end
      check_out("gap_hold", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
      step(1'b1, 1'b0, 8'h44);
      check_out("gap", 8'h11, 8'h22, 8'h33, 8'h44);
      check("gap_valid_count", n_valid, 32'd1);

      // Early SYNC resync.
      n_valid = 0;
      n_err   = 0;
      step(1'b1, 1'b1, 8'h11);
      step(1'b1, 1'b0, 8'h22);
      step(1'b1, 1'b1, 8'h55);
      check("early_ERR", {31'd0, ERR}, 32'd1);
      check("early_LOCK", {31'd0, LOCK}, 32'd1);
      check("early_SEL", {30'd0, SEL}, 32'd1);
      step(1'b1, 1'b0, 8'h66);
      check("early_ERR_pulse", {31'd0, ERR}, 32'd0);
      step(1'b1, 1'b0, 8'h77);
      step(1'b1, 1'b0, 8'h88);
      check_out("early", 8'h55, 8'h66, 8'h77, 8'h88);
      check("early_valid_count", n_valid, 32'd1);
      check("early_err_count", n_err, 32'd1);

      // Missing SYNC drops lock; outputs hold; relock on next marker.
      step(1'b1, 1'b0, 8'h99);
      check("miss_ERR", {31'd0, ERR}, 32'd1);
      check("miss_LOCK", {31'd0, LOCK}, 32'd0);
      check("miss_SEL", {30'd0, SEL}, 32'd0);
      check_out("miss_hold", 8'h55, 8'h66, 8'h77, 8'h88);
      step(1'b1, 1'b0, 8'h9A);
      check("miss_ERR_once", {31'd0, ERR}, 32'd0);
      step(1'b1, 1'b1, 8'h01);
      check("relock_LOCK", {31'd0, LOCK}, 32'd1);
      step(1'b1, 1'b0, 8'h02);
      step(1'b1, 1'b0, 8'h03);
      step(1'b1, 1'b0, 8'h04);
      check_out("relock", 8'h01, 8'h02, 8'h03, 8'h04);
      check("relock_VALID", {31'd0, VALID}, 32'd1);

      // Asynchronous reset mid-frame.
      step(1'b1, 1'b1, 8'h11);
      step(1'b1, 1'b0, 8'h22);
      #2;
      RST = 1'b1;
      #1;
      check_out("arst", 8'h00, 8'h00, 8'h00, 8'h00);
      check("arst_LOCK", {31'd0, LOCK}, 32'd0);
      check("arst_SEL",  {30'd0, SEL}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      n_valid = 0;
      n_err   = 0;
      step(1'b1, 1'b0, 8'h33);
      step(1'b1, 1'b0, 8'h44);
      check("arst_no_valid", n_valid, 32'd0);
      check("arst_no_err", n_err, 32'd0);
      check("arst_unlocked", {31'd0, LOCK}, 32'd0);
      check_out("arst_hold", 8'h00, 8'h00, 8'h00, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
